// File: rtl/mst_arb_pkg.sv
// Shared types and constants for the master-channel round-robin burst arbiter.
// BURST_DEFAULT of 256 words fills one 512-byte FT600 packet in 16-bit mode.
package mst_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int BURST_DEFAULT = 256;

    // Width of a channel index; never narrower than one bit.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mst_rr_pick.sv
// Combinational round-robin picker: first eligible channel scanning upward
// from ptr+1, wrapping modulo NCH, with ptr itself considered last.
module mst_rr_pick
    import mst_arb_pkg::*;
#(
    parameter int NCH = 4,
    localparam int IW = ch_idx_w(NCH)
) (
    input  logic [NCH-1:0] eligible,
    input  logic [IW-1:0]  ptr,
    output logic           any,
    output logic [IW-1:0]  idx
);

    logic [IW-1:0] cand;

    // Scan from the farthest offset down to the nearest so the nearest eligible
    // channel is the last to overwrite idx; NCH is a power of two so the index
    // wraps by plain truncation.
    always_comb begin
        any  = 1'b0;
        idx  = ptr;
        cand = ptr;
        for (int k = NCH; k >= 1; k--) begin
            cand = ptr + IW'(k);
            if (eligible[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/mst_ch_arb.sv
// Round-robin burst arbiter feeding the master FIFO write path from NCH
// first-word-fall-through generator channels, up to BURST words per grant.
module mst_ch_arb
    import mst_arb_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int DW    = 16,
    parameter int BURST = BURST_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NCH-1:0]           ch_en,
    input  logic [NCH-1:0]           ch_rdy,
    input  logic [NCH*DW-1:0]        ch_dat,
    output logic [NCH-1:0]           ch_req,
    input  logic                     dn_req,
    output logic [DW-1:0]            dn_dat,
    output logic                     dn_vld,
    output logic [ch_idx_w(NCH)-1:0] dn_ch,
    output logic                     dn_eop,
    output logic                     busy
);

    localparam int IW = ch_idx_w(NCH);
    localparam int CW = $clog2(BURST) + 1;

    arb_state_e    state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] gnt_q, gnt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] dn_dat_q, dn_dat_d;
    logic          dn_vld_q, dn_vld_d;
    logic [IW-1:0] dn_ch_q, dn_ch_d;
    logic          dn_eop_q, dn_eop_d;
    logic          busy_q, busy_d;

    logic [NCH-1:0] elig;
    logic           pick_any;
    logic [IW-1:0]  pick_idx;
    logic           gnt_ok;
    logic           pop;

    assign elig   = ch_rdy & ch_en;
    assign gnt_ok = ch_rdy[gnt_q] & ch_en[gnt_q];
    assign pop    = (state_q == GRANT) & dn_req & gnt_ok;

    mst_rr_pick #(
        .NCH (NCH)
    ) u_pick (
        .eligible (elig),
        .ptr      (ptr_q),
        .any      (pick_any),
        .idx      (pick_idx)
    );

    // Pop strobe is combinational so the channel advances in the same cycle
    // its word is captured.
    always_comb begin
        ch_req        = '0;
        ch_req[gnt_q] = pop;
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        cnt_d    = cnt_q;
        dn_dat_d = dn_dat_q;
        dn_ch_d  = dn_ch_q;
        dn_vld_d = 1'b0;
        dn_eop_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    gnt_d   = pick_idx;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // A pop on the quota word ends the grant even if the channel
                // drops ready afterwards.
                if (pop) begin
                    dn_dat_d = ch_dat[int'(gnt_q)*DW +: DW];
                    dn_ch_d  = gnt_q;
                    dn_vld_d = 1'b1;
                    cnt_d    = cnt_q + CW'(1);
                    if (cnt_q == CW'(BURST - 1)) begin
                        dn_eop_d = 1'b1;
                        ptr_d    = gnt_q;
                        state_d  = IDLE;
                    end
                end else if (!gnt_ok) begin
                    ptr_d   = gnt_q;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == GRANT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= IW'(NCH - 1);
            gnt_q    <= '0;
            cnt_q    <= '0;
            dn_dat_q <= '0;
            dn_vld_q <= 1'b0;
            dn_ch_q  <= '0;
            dn_eop_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            cnt_q    <= cnt_d;
            dn_dat_q <= dn_dat_d;
            dn_vld_q <= dn_vld_d;
            dn_ch_q  <= dn_ch_d;
            dn_eop_q <= dn_eop_d;
            busy_q   <= busy_d;
        end
    end

    assign dn_dat = dn_dat_q;
    assign dn_vld = dn_vld_q;
    assign dn_ch  = dn_ch_q;
    assign dn_eop = dn_eop_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_mst_ch_arb.sv
// Directed bench for mst_ch_arb with NCH=4, DW=16, BURST=4: a cycle table for
// the main arbitration flow plus hand sequences for the multi-cycle corners.
module tb_mst_ch_arb;

    localparam int NCH   = 4;
    localparam int DW    = 16;
    localparam int BURST = 4;

    logic              clk;
    logic              rst_n;
    logic [NCH-1:0]    ch_en;
    logic [NCH-1:0]    ch_rdy;
    logic [NCH*DW-1:0] ch_dat;
    logic [NCH-1:0]    ch_req;
    logic              dn_req;
    logic [DW-1:0]     dn_dat;
    logic              dn_vld;
    logic [1:0]        dn_ch;
    logic              dn_eop;
    logic              busy;

    int nVec;
    int nMiss;

    typedef struct {
        logic [3:0]  en;
        logic [3:0]  rdy;
        logic        req;
        logic [3:0]  eReq;
        logic        eVld;
        logic [15:0] eDat;
        logic [1:0]  eCh;
        logic        eEop;
        logic        eBusy;
    } vec_t;

    vec_t vecs[$];

    logic [15:0] wcnt [NCH];

    mst_ch_arb #(
        .NCH   (NCH),
        .DW    (DW),
        .BURST (BURST)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ch_en  (ch_en),
        .ch_rdy (ch_rdy),
        .ch_dat (ch_dat),
        .ch_req (ch_req),
        .dn_req (dn_req),
        .dn_dat (dn_dat),
        .dn_vld (dn_vld),
        .dn_ch  (dn_ch),
        .dn_eop (dn_eop),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each channel is a FWFT source whose n-th word is ch*0x1000 + n.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            ch_dat[i*DW +: DW] = 16'(i * 16'h1000) + wcnt[i];
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) wcnt[i] <= 16'h0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (ch_req[i]) wcnt[i] <= wcnt[i] + 16'h1;
            end
        end
    end

    task automatic applyStimulus(input logic [3:0] en, input logic [3:0] rdy, input logic req);
        ch_en  = en;
        ch_rdy = rdy;
        dn_req = req;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMiss++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic doReset();
        applyStimulus(4'h0, 4'h0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk(input logic [3:0] rdy, input logic req, input logic [3:0] eReq,
                                input logic eVld, input logic [15:0] eDat, input logic [1:0] eCh,
                                input logic eEop, input logic eBusy);
        vec_t v;
        v.en    = 4'hF;
        v.rdy   = rdy;
        v.req   = req;
        v.eReq  = eReq;
        v.eVld  = eVld;
        v.eDat  = eDat;
        v.eCh   = eCh;
        v.eEop  = eEop;
        v.eBusy = eBusy;
        return v;
    endfunction

    initial begin
        int ch1Words;
        int eops;
        int badReq;
        int badCh;
        int nWords;
        int eopAt;
        logic [9:0] expReq;
        logic [9:0] expVld;
        logic [9:0] expEop;

        nVec  = 0;
        nMiss = 0;
        rst_n = 1'b0;
        applyStimulus(4'h0, 4'h0, 1'b0);

        // Only ch0 ready: two bursts of 4 with one idle bubble, then all ready.
        vecs.push_back(mk(4'h1, 1, 4'h0, 0, 16'h0000, 0, 0, 0));
        vecs.push_back(mk(4'h1, 1, 4'h1, 0, 16'h0000, 0, 0, 1));
        vecs.push_back(mk(4'h1, 1, 4'h1, 1, 16'h0000, 0, 0, 1));
        vecs.push_back(mk(4'h1, 1, 4'h1, 1, 16'h0001, 0, 0, 1));
        vecs.push_back(mk(4'h1, 1, 4'h1, 1, 16'h0002, 0, 0, 1));
        vecs.push_back(mk(4'h1, 1, 4'h0, 1, 16'h0003, 0, 1, 0));
        vecs.push_back(mk(4'h1, 1, 4'h1, 0, 16'h0000, 0, 0, 1));
        vecs.push_back(mk(4'hF, 1, 4'h1, 1, 16'h0004, 0, 0, 1));
        vecs.push_back(mk(4'hF, 1, 4'h1, 1, 16'h0005, 0, 0, 1));
        vecs.push_back(mk(4'hF, 1, 4'h1, 1, 16'h0006, 0, 0, 1));
        vecs.push_back(mk(4'hF, 1, 4'h0, 1, 16'h0007, 0, 1, 0));
        vecs.push_back(mk(4'hF, 1, 4'h2, 0, 16'h0000, 0, 0, 1));
        vecs.push_back(mk(4'hF, 1, 4'h2, 1, 16'h1000, 1, 0, 1));
        vecs.push_back(mk(4'hF, 1, 4'h2, 1, 16'h1001, 1, 0, 1));
        vecs.push_back(mk(4'hF, 1, 4'h2, 1, 16'h1002, 1, 0, 1));
        vecs.push_back(mk(4'hF, 1, 4'h0, 1, 16'h1003, 1, 1, 0));
        vecs.push_back(mk(4'hF, 1, 4'h4, 0, 16'h0000, 0, 0, 1));
        vecs.push_back(mk(4'hF, 1, 4'h4, 1, 16'h2000, 2, 0, 1));
        vecs.push_back(mk(4'hF, 1, 4'h4, 1, 16'h2001, 2, 0, 1));
        vecs.push_back(mk(4'hF, 1, 4'h4, 1, 16'h2002, 2, 0, 1));
        vecs.push_back(mk(4'hF, 1, 4'h0, 1, 16'h2003, 2, 1, 0));
        vecs.push_back(mk(4'hF, 1, 4'h8, 0, 16'h0000, 0, 0, 1));
        vecs.push_back(mk(4'hF, 1, 4'h8, 1, 16'h3000, 3, 0, 1));
        vecs.push_back(mk(4'hF, 1, 4'h8, 1, 16'h3001, 3, 0, 1));
        vecs.push_back(mk(4'hF, 1, 4'h8, 1, 16'h3002, 3, 0, 1));
        vecs.push_back(mk(4'hF, 1, 4'h0, 1, 16'h3003, 3, 1, 0));
        vecs.push_back(mk(4'hF, 1, 4'h1, 0, 16'h0000, 0, 0, 1));
        vecs.push_back(mk(4'hF, 1, 4'h1, 1, 16'h0008, 0, 0, 1));

        doReset();
        checkOutput("resetDat", 32'(dn_dat), 32'h0);
        checkOutput("resetCh", 32'(dn_ch), 32'h0);
        for (int v = 0; v < vecs.size(); v++) begin
            applyStimulus(vecs[v].en, vecs[v].rdy, vecs[v].req);
            #1;
            checkOutput($sformatf("v%0d.ch_req", v), 32'(ch_req), 32'(vecs[v].eReq));
            checkOutput($sformatf("v%0d.dn_vld", v), 32'(dn_vld), 32'(vecs[v].eVld));
            checkOutput($sformatf("v%0d.dn_eop", v), 32'(dn_eop), 32'(vecs[v].eEop));
            checkOutput($sformatf("v%0d.busy", v), 32'(busy), 32'(vecs[v].eBusy));
            if (vecs[v].eVld) begin
                checkOutput($sformatf("v%0d.dn_dat", v), 32'(dn_dat), 32'(vecs[v].eDat));
                checkOutput($sformatf("v%0d.dn_ch", v), 32'(dn_ch), 32'(vecs[v].eCh));
            end
            @(negedge clk);
        end

        // Channel 1 drops ready after two pops while dn_req stays high.
        doReset();
        applyStimulus(4'hF, 4'b0010, 1'b1);
        ch1Words = 0;
        eops     = 0;
        for (int c = 0; c < 6; c++) begin
            if (c == 3) ch_rdy = 4'b0100;
            #1;
            if (c == 3) checkOutput("earlyEndNoPop", 32'(ch_req), 32'h0);
            if (c == 5) checkOutput("nextGrantCh2", 32'(ch_req), 32'h4);
            if (dn_vld && dn_ch == 2'd1) ch1Words++;
            if (dn_vld && dn_eop) eops++;
            @(negedge clk);
        end
        checkOutput("earlyEndWords", 32'(ch1Words), 32'd2);
        checkOutput("earlyEndNoEop", 32'(eops), 32'd0);

        // Channel 2 disabled while everything is ready.
        doReset();
        applyStimulus(4'b1011, 4'hF, 1'b1);
        badReq = 0;
        badCh  = 0;
        eops   = 0;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (ch_req[2]) badReq++;
            if (dn_vld && dn_ch == 2'd2) badCh++;
            if (dn_vld && dn_eop) eops++;
            @(negedge clk);
        end
        checkOutput("disabledReq", 32'(badReq), 32'd0);
        checkOutput("disabledCh", 32'(badCh), 32'd0);
        checkOutput("disabledEops", 32'(eops), 32'd19);

        // dn_req toggling during a grant; the req in the idle cycle is dropped.
        doReset();
        applyStimulus(4'hF, 4'h1, 1'b1);
        expReq = 10'h2AA;
        expVld = 10'h154;
        expEop = 10'h100;
        for (int c = 0; c < 10; c++) begin
            dn_req = (c == 0) ? 1'b1 : 1'(c % 2);
            #1;
            checkOutput($sformatf("tog%0d.ch_req", c), 32'(ch_req), 32'(expReq[c]));
            checkOutput($sformatf("tog%0d.dn_vld", c), 32'(dn_vld), 32'(expVld[c]));
            checkOutput($sformatf("tog%0d.dn_eop", c), 32'(dn_eop), 32'(expEop[c]));
            @(negedge clk);
        end

        // Asynchronous reset in the middle of channel 1's burst.
        doReset();
        applyStimulus(4'hF, 4'hF, 1'b1);
        repeat (7) @(negedge clk);
        #1;
        checkOutput("preResetBusy", 32'(busy), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncRstReq", 32'(ch_req), 32'h0);
        checkOutput("asyncRstVld", 32'(dn_vld), 32'h0);
        checkOutput("asyncRstDat", 32'(dn_dat), 32'h0);
        checkOutput("asyncRstCh", 32'(dn_ch), 32'h0);
        checkOutput("asyncRstEop", 32'(dn_eop), 32'h0);
        checkOutput("asyncRstBusy", 32'(busy), 32'h0);
        @(negedge clk);
        rst_n  = 1'b1;
        nWords = 0;
        eopAt  = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (c == 0) checkOutput("postRstIdle", 32'(ch_req), 32'h0);
            if (c == 1) checkOutput("postRstGnt0", 32'(ch_req), 32'h1);
            if (dn_vld) begin
                nWords++;
                if (nWords == 1) checkOutput("postRstCh", 32'(dn_ch), 32'h0);
                if (dn_eop) eopAt = nWords;
            end
            @(negedge clk);
        end
        checkOutput("postRstEopAt", 32'(eopAt), 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

endmodule

// File: doc/mst_ch_arb.md
# mst_ch_arb

Round-robin burst arbiter that shares the master FIFO write-path word source between NCH streaming generator channels. It sits between the prefetch stage, which pulls one word per request, and the per-channel generators. It grants one channel at a time for up to BURST words, tags each delivered word with its channel, and flags the last word of a full-quota burst. The bus FSM can then close an FT600 packet on that word.

## Interface
Parameters:
- NCH, 4, number of requester channels (power of 2, ≥2)
- DW, 16, data word width
- BURST, 256, max words per grant (≥2)

Ports:
- clk  in  1  system clock (FIFO bus CLK domain)
- rst_n  in  1  reset, asynchronous, active-low
- ch_en  in  NCH  per-channel enable mask
- ch_rdy  in  NCH  channel has a word available; its word is shown first-word-fall-through on ch_dat
- ch_dat  in  NCH*DW  channel words, channel i at [i*DW +: DW]
- ch_req  out  NCH  pop strobe to channel, one-hot or zero
- dn_req  in  1  downstream pull request, one word per cycle
- dn_dat  out  DW  delivered word
- dn_vld  out  1  dn_dat valid this cycle
- dn_ch  out  log2(NCH)  channel that sourced dn_dat
- dn_eop  out  1  dn_dat is the BURST-th word of its grant
- busy  out  1  a grant is active

## Operation
- States: IDLE, GRANT.
- Eligible set: ch_rdy & ch_en.
- IDLE:
  - If the eligible set is non-empty, pick the first eligible channel scanning upward (mod NCH) from ptr+1.
  - Register it as gnt, clear cnt, go to GRANT.
  - ch_req = 0 in IDLE. A dn_req arriving in IDLE is dropped (dn_vld=0 next cycle).
- GRANT:
  - pop = dn_req & ch_rdy[gnt] & ch_en[gnt].
  - ch_req[gnt] = pop, combinational.
  - On pop: dn_dat ← ch_dat[gnt], dn_ch ← gnt, dn_vld ← 1, cnt++.
  - On pop with cnt == BURST-1: dn_eop ← 1, ptr ← gnt, go IDLE.
  - Without pop, if ch_rdy[gnt]=0 or ch_en[gnt]=0: early end. ptr ← gnt, go IDLE, no dn_eop.
  - Without pop while still eligible (dn_req low): hold. No timeout.
- Never more than one ch_req bit high. Never a ch_req without a same-cycle dn_req.
- cnt width is clog2(BURST)+1, saturating arithmetic not needed (it is cleared on every grant).
- Simultaneous events:
  - dn_req together with ch_rdy[gnt] falling in the same cycle: no pop, early end.
  - Quota reached in the same cycle as ch_rdy falling afterwards: quota end wins, because the pop already happened.
- Reset state: state=IDLE, ptr=NCH-1 (channel 0 wins first), gnt=0, cnt=0.
- Output values in reset: ch_req=0, dn_dat=0, dn_vld=0, dn_ch=0, dn_eop=0, busy=0.
- An asynchronous reset mid-burst aborts immediately. The partial burst is not resumed.

## Timing
- ch_req is combinational from dn_req, state, ch_rdy and ch_en, with zero latency.
- dn_dat, dn_vld, dn_ch and dn_eop are registered, 1 cycle after the pop.
- busy = (state==GRANT), registered.
- Arbitration: eligible in IDLE at cycle t → GRANT at t+1 → first pop possible at t+1 → first dn_vld at t+2.
- Burst-to-burst: 1 IDLE bubble cycle between grants. Sustained throughput is BURST/(BURST+1) words per cycle when all channels stay ready.
- dn_vld is a single-cycle pulse per word. Back-to-back pulses occur when dn_req is held high.

## Structure
- Package mst_arb_pkg: state enum (IDLE, GRANT), default BURST constant (256 = 512-byte FT600 packet in 16-bit mode), channel-index width function.
- Sub-module mst_rr_pick: combinational round-robin picker.
  - Inputs: eligible NCH, ptr.
  - Outputs: any, idx.
  - Instantiated once.

## Test plan
- Reset, then ch_en=4'hF, ch_rdy=4'h1, dn_req held high, BURST=4 → ch_req[0] pulses on 4 consecutive cycles; dn_vld on 4 cycles with dn_ch=0; dn_eop on the 4th word only; 1 idle cycle; then a new grant to channel 0.
- All four channels ready continuously, BURST=4, dn_req high → grant order 0,1,2,3,0; each burst 4 words with dn_eop on the last; 1 bubble cycle between bursts.
- Channel 1 granted, ch_rdy[1] drops after 2 pops → exactly 2 words with dn_ch=1, no dn_eop; next grant goes to channel 2 if ready.
- ch_en[2]=0 with ch_rdy=4'hF → channel 2 is never granted and ch_req[2] stays 0 for 100 cycles.
- dn_req toggled 1-0-1-0 during a grant → ch_req and dn_vld follow dn_req with 0- and 1-cycle lag; the burst still ends after exactly BURST pops.
- rst_n asserted mid-burst, asynchronous to clk → all outputs 0 with no clock edge; after release, channel 0 is granted first and cnt restarts at 0.
